pipe_hazard_ctrl: RTL and testbench

- Hazard, forwarding and exception sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Generates PC/IF_ID write enables, stage flushes, EX and jr forwarding selects, and the PC-source override for interrupts and exceptions.
- Holds a registered interrupt FSM that delays IRQ entry to a safe cycle and tracks the kernel handler until it returns.
- Sits beside Control, between the pipeline registers and the PC mux.

---
 rtl/pipe_hazard_ctrl_if.sv | 56 +++++
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the MIPS pipeline datapath and the hazard controller.
// master: pipeline side (drives stage fields, consumes control).
// slave : pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
    parameter int WAIT_W = 8
);
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_jr;
    logic              id_jump;
    logic              id_illop;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_wr_addr;
    logic              ex_regwr;
    logic              ex_memrd;
    logic              ex_branch_taken;
    logic [4:0]        mem_wr_addr;
    logic              mem_regwr;
    logic              mem_memrd;
    logic [4:0]        wb_wr_addr;
    logic              wb_regwr;
    logic              irq;
    logic              kernel;

    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [1:0]        fwd_jr;
    logic [2:0]        pc_ovr;
    logic              xp_take;
    logic [WAIT_W-1:0] irq_wait;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_jr, id_jump, id_illop,
        output ex_rs, ex_rt, ex_wr_addr, ex_regwr, ex_memrd, ex_branch_taken,
        output mem_wr_addr, mem_regwr, mem_memrd, wb_wr_addr, wb_regwr,
        output irq, kernel,
        input  pc_write, ifid_write, ifid_flush, idex_flush,
        input  fwd_a, fwd_b, fwd_jr, pc_ovr, xp_take, irq_wait
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_jr, id_jump, id_illop,
        input  ex_rs, ex_rt, ex_wr_addr, ex_regwr, ex_memrd, ex_branch_taken,
        input  mem_wr_addr, mem_regwr, mem_memrd, wb_wr_addr, wb_regwr,
        input  irq, kernel,
        output pc_write, ifid_write, ifid_flush, idex_flush,
        output fwd_a, fwd_b, fwd_jr, pc_ovr, xp_take, irq_wait
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and exception/interrupt sequencer for the 5-stage MIPS pipeline.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no interrupt outstanding, user code running
// PEND  | IRQ latched, waiting for a safe cycle to redirect to ILLOP
// KERN  | kernel handler running; wait for PC[31] to fall (jr $26)
module pipe_hazard_ctrl #(
    parameter int WAIT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        KERN = 2'd2
    } state_t;

    localparam logic [2:0] OVR_NONE = 3'd0;
    localparam logic [2:0] OVR_IRQ  = 3'd4;
    localparam logic [2:0] OVR_EXC  = 3'd5;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic [WAIT_W-1:0] irq_wait_q;

    logic load_use;
    logic jr_stall;
    logic stall;
    logic br_flush;
    logic exc;
    logic take;

    // $0 is hardwired, so a match on it is never a real dependency
    function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    // youngest in-flight producer wins: MEM before WB
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       m_we, input logic [4:0] m_wa,
                                           input logic       w_we, input logic [4:0] w_wa);
        if (m_we && reg_hit(src, m_wa))
            return 2'd1;
        else if (w_we && reg_hit(src, w_wa))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    // hazard detection and event qualification
    always_comb begin
        load_use = hz.ex_memrd &&
                   ((hz.id_use_rs && reg_hit(hz.id_rs, hz.ex_wr_addr)) ||
                    (hz.id_use_rt && reg_hit(hz.id_rt, hz.ex_wr_addr)));
        // jr reads rs in ID: an EX producer or a MEM load cannot be forwarded in time
        jr_stall = hz.id_jr &&
                   ((hz.ex_regwr && reg_hit(hz.id_rs, hz.ex_wr_addr)) ||
                    (hz.mem_memrd && reg_hit(hz.id_rs, hz.mem_wr_addr)));
        stall    = load_use || jr_stall;
        br_flush = hz.ex_branch_taken;
        // a squashed ID instruction can neither fault nor be interrupted
        exc      = hz.id_illop && !hz.kernel && !br_flush;
        take     = (state == PEND) && !hz.kernel && !stall && !br_flush && !exc && !hz.id_jump;
    end

    assign wait_next = (wait_cnt == {WAIT_W{1'b1}}) ? wait_cnt : wait_cnt + WAIT_W'(1);

    // prioritised pipeline control: branch > exception > irq take > stall > jump
    always_comb begin
        hz.pc_write   = 1'b1;
        hz.ifid_write = 1'b1;
        hz.ifid_flush = 1'b0;
        hz.idex_flush = 1'b0;
        hz.pc_ovr     = OVR_NONE;
        hz.xp_take    = 1'b0;
        hz.fwd_a      = fwd_sel(hz.ex_rs, hz.mem_regwr, hz.mem_wr_addr, hz.wb_regwr, hz.wb_wr_addr);
        hz.fwd_b      = fwd_sel(hz.ex_rt, hz.mem_regwr, hz.mem_wr_addr, hz.wb_regwr, hz.wb_wr_addr);
        hz.fwd_jr     = jr_stall ? 2'd0
                                 : fwd_sel(hz.id_rs, hz.mem_regwr, hz.mem_wr_addr,
                                           hz.wb_regwr, hz.wb_wr_addr);
        if (br_flush) begin
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
        end else if (exc) begin
            hz.pc_ovr     = OVR_EXC;
            hz.xp_take    = 1'b1;
            hz.ifid_flush = 1'b1;
        end else if (take) begin
            hz.pc_ovr     = OVR_IRQ;
            hz.xp_take    = 1'b1;
            hz.ifid_flush = 1'b1;
        end else if (stall) begin
            hz.pc_write   = 1'b0;
            hz.ifid_write = 1'b0;
            hz.idex_flush = 1'b1;
        end else if (hz.id_jump) begin
            hz.ifid_flush = 1'b1;
        end
    end

    // interrupt sequencer with saturating pending-time counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            irq_wait_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hz.irq && !hz.kernel) begin
                        state    <= PEND;
                        wait_cnt <= '0;
                    end
                end
                PEND: begin
                    wait_cnt <= wait_next;
                    if (take) begin
                        irq_wait_q <= wait_next;
                        state      <= KERN;
                    end else if (exc || hz.kernel) begin
                        // an exception got into the kernel first; the IRQ is serviced later
                        state <= KERN;
                    end
                end
                KERN: begin
                    if (!hz.kernel)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign hz.irq_wait = irq_wait_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed pipeline scenarios followed by
// random traffic, checked against a rule-level reference model.
module tb_pipe_hazard_ctrl;
    localparam int WAIT_W = 8;
    localparam int WAIT_MAX = (1 << WAIT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.WAIT_W(WAIT_W)) hz();

    pipe_hazard_ctrl #(.WAIT_W(WAIT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    typedef struct packed {
        logic [4:0] id_rs, id_rt;
        logic       id_use_rs, id_use_rt, id_jr, id_jump, id_illop;
        logic [4:0] ex_rs, ex_rt, ex_wr_addr;
        logic       ex_regwr, ex_memrd, ex_branch_taken;
        logic [4:0] mem_wr_addr;
        logic       mem_regwr, mem_memrd;
        logic [4:0] wb_wr_addr;
        logic       wb_regwr, irq, kernel, rst_n;
    } stim_t;

    typedef struct packed {
        logic              pc_write, ifid_write, ifid_flush, idex_flush;
        logic [1:0]        fwd_a, fwd_b, fwd_jr;
        logic [2:0]        pc_ovr;
        logic              xp_take;
        logic [WAIT_W-1:0] irq_wait;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // reference model state: is an IRQ outstanding, is a handler running, how long it waited
    bit m_pending = 0;
    bit m_in_handler = 0;
    int m_waited = 0;
    int m_last_wait = 0;
    bit r_kernel = 0;

    function automatic bool_hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] src_of(input logic [4:0] r, input stim_t s);
        if (s.mem_regwr && bool_hit(r, s.mem_wr_addr)) return 2'd1;
        if (s.wb_regwr && bool_hit(r, s.wb_wr_addr))   return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_step(input stim_t s, output exp_t e);
        bit lu, js, st, br, ex, tk;
        if (!s.rst_n) begin
            m_pending = 0; m_in_handler = 0; m_waited = 0; m_last_wait = 0;
        end
        lu = s.ex_memrd && ((s.id_use_rs && bool_hit(s.id_rs, s.ex_wr_addr)) ||
                            (s.id_use_rt && bool_hit(s.id_rt, s.ex_wr_addr)));
        js = s.id_jr && ((s.ex_regwr && bool_hit(s.id_rs, s.ex_wr_addr)) ||
                         (s.mem_memrd && bool_hit(s.id_rs, s.mem_wr_addr)));
        st = lu || js;
        br = s.ex_branch_taken;
        ex = s.id_illop && !s.kernel && !br;
        tk = s.rst_n && m_pending && !s.kernel && !st && !br && !ex && !s.id_jump;

        e = '0;
        e.pc_write = 1'b1;
        e.ifid_write = 1'b1;
        e.fwd_a = src_of(s.ex_rs, s);
        e.fwd_b = src_of(s.ex_rt, s);
        e.fwd_jr = js ? 2'd0 : src_of(s.id_rs, s);
        if (br) begin
            e.ifid_flush = 1; e.idex_flush = 1;
        end else if (ex) begin
            e.pc_ovr = 3'd5; e.xp_take = 1; e.ifid_flush = 1;
        end else if (tk) begin
            e.pc_ovr = 3'd4; e.xp_take = 1; e.ifid_flush = 1;
        end else if (st) begin
            e.pc_write = 0; e.ifid_write = 0; e.idex_flush = 1;
        end else if (s.id_jump) begin
            e.ifid_flush = 1;
        end
        e.irq_wait = WAIT_W'((m_last_wait > WAIT_MAX) ? WAIT_MAX : m_last_wait);

        if (s.rst_n) begin
            if (m_pending) begin
                m_waited++;
                if (tk) begin
                    m_last_wait = m_waited; m_pending = 0; m_in_handler = 1;
                end else if (ex || s.kernel) begin
                    m_pending = 0; m_in_handler = 1;
                end
            end else if (m_in_handler) begin
                if (!s.kernel) m_in_handler = 0;
            end else if (s.irq && !s.kernel) begin
                m_pending = 1; m_waited = 0;
            end
        end
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        reset              = s.rst_n;
        hz.id_rs           = s.id_rs;
        hz.id_rt           = s.id_rt;
        hz.id_use_rs       = s.id_use_rs;
        hz.id_use_rt       = s.id_use_rt;
        hz.id_jr           = s.id_jr;
        hz.id_jump         = s.id_jump;
        hz.id_illop        = s.id_illop;
        hz.ex_rs           = s.ex_rs;
        hz.ex_rt           = s.ex_rt;
        hz.ex_wr_addr      = s.ex_wr_addr;
        hz.ex_regwr        = s.ex_regwr;
        hz.ex_memrd        = s.ex_memrd;
        hz.ex_branch_taken = s.ex_branch_taken;
        hz.mem_wr_addr     = s.mem_wr_addr;
        hz.mem_regwr       = s.mem_regwr;
        hz.mem_memrd       = s.mem_memrd;
        hz.wb_wr_addr      = s.wb_wr_addr;
        hz.wb_regwr        = s.wb_regwr;
        hz.irq             = s.irq;
        hz.kernel          = s.kernel;
        model_step(s, e);
        sb.push_back(e);
    endtask

    function automatic stim_t quiet();
        stim_t s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = quiet();
        if ($urandom_range(0, 15) == 0) r_kernel = ~r_kernel;
        s.kernel          = r_kernel;
        s.id_rs           = 5'($urandom_range(0, 3));
        s.id_rt           = 5'($urandom_range(0, 3));
        s.id_use_rs       = 1'($urandom);
        s.id_use_rt       = 1'($urandom);
        s.id_jr           = ($urandom_range(0, 5) == 0);
        s.id_jump         = s.id_jr || ($urandom_range(0, 7) == 0);
        s.id_illop        = ($urandom_range(0, 15) == 0);
        s.ex_rs           = 5'($urandom_range(0, 3));
        s.ex_rt           = 5'($urandom_range(0, 3));
        s.ex_wr_addr      = 5'($urandom_range(0, 3));
        s.ex_regwr        = 1'($urandom);
        s.ex_memrd        = ($urandom_range(0, 3) == 0);
        s.ex_branch_taken = ($urandom_range(0, 7) == 0);
        s.mem_wr_addr     = 5'($urandom_range(0, 3));
        s.mem_regwr       = 1'($urandom);
        s.mem_memrd       = ($urandom_range(0, 3) == 0);
        s.wb_wr_addr      = 5'($urandom_range(0, 3));
        s.wb_regwr        = 1'($urandom);
        s.irq             = ($urandom_range(0, 3) == 0);
        s.rst_n           = ($urandom_range(0, 199) != 0);
        return s;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, want);
        end
    endfunction

    // monitor: compare the DUT against the oldest expectation, mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cyc++;
                chk("pc_write",   32'(hz.pc_write),   32'(e.pc_write));
                chk("ifid_write", 32'(hz.ifid_write), 32'(e.ifid_write));
                chk("ifid_flush", 32'(hz.ifid_flush), 32'(e.ifid_flush));
                chk("idex_flush", 32'(hz.idex_flush), 32'(e.idex_flush));
                chk("fwd_a",      32'(hz.fwd_a),      32'(e.fwd_a));
                chk("fwd_b",      32'(hz.fwd_b),      32'(e.fwd_b));
                chk("fwd_jr",     32'(hz.fwd_jr),     32'(e.fwd_jr));
                chk("pc_ovr",     32'(hz.pc_ovr),     32'(e.pc_ovr));
                chk("xp_take",    32'(hz.xp_take),    32'(e.xp_take));
                chk("irq_wait",   32'(hz.irq_wait),   32'(e.irq_wait));
            end
        end
    end

    // stimulus: directed pipeline scenarios, then random traffic
    initial begin
        stim_t s;
        s = quiet(); s.rst_n = 1'b0; apply(s); apply(s);
        s = quiet(); apply(s);

        // add $1; add $2,$1,$1; add $3,$1,$2
        s = quiet(); s.ex_rs = 5'd1; s.ex_rt = 5'd1; s.mem_regwr = 1; s.mem_wr_addr = 5'd1; apply(s);
        s = quiet(); s.ex_rs = 5'd1; s.ex_rt = 5'd2; s.mem_regwr = 1; s.mem_wr_addr = 5'd2;
        s.wb_regwr = 1; s.wb_wr_addr = 5'd1; apply(s);

        // lw $4; add $5,$4,$0
        s = quiet(); s.ex_memrd = 1; s.ex_regwr = 1; s.ex_wr_addr = 5'd4;
        s.id_rs = 5'd4; s.id_use_rs = 1; s.id_use_rt = 1; apply(s);
        s = quiet(); s.mem_memrd = 1; s.mem_regwr = 1; s.mem_wr_addr = 5'd4;
        s.id_rs = 5'd4; s.id_use_rs = 1; s.id_use_rt = 1; apply(s);
        s = quiet(); s.wb_regwr = 1; s.wb_wr_addr = 5'd4; s.ex_rs = 5'd4; apply(s);
        s = quiet(); s.ex_memrd = 1; s.ex_regwr = 1; s.ex_wr_addr = 5'd0;
        s.id_use_rs = 1; s.id_use_rt = 1; apply(s);

        // lw $31; jr $31
        s = quiet(); s.id_jr = 1; s.id_jump = 1; s.id_rs = 5'd31; s.id_use_rs = 1;
        s.ex_memrd = 1; s.ex_regwr = 1; s.ex_wr_addr = 5'd31; apply(s);
        s.ex_memrd = 0; s.ex_regwr = 0; s.ex_wr_addr = 5'd0;
        s.mem_memrd = 1; s.mem_regwr = 1; s.mem_wr_addr = 5'd31; apply(s);
        s.mem_memrd = 0; s.mem_regwr = 0; s.mem_wr_addr = 5'd0;
        s.wb_regwr = 1; s.wb_wr_addr = 5'd31; apply(s);
        // addi $31; jr $31
        s = quiet(); s.id_jr = 1; s.id_jump = 1; s.id_rs = 5'd31; s.id_use_rs = 1;
        s.ex_regwr = 1; s.ex_wr_addr = 5'd31; apply(s);
        s.ex_regwr = 0; s.ex_wr_addr = 5'd0; s.mem_regwr = 1; s.mem_wr_addr = 5'd31; apply(s);

        // taken branch squashes an illop while an IRQ is pending
        s = quiet(); s.irq = 1; apply(s);
        s = quiet(); s.irq = 1; s.ex_branch_taken = 1; s.id_illop = 1; apply(s);
        s = quiet(); apply(s);
        s = quiet(); s.kernel = 1; apply(s); apply(s);
        s = quiet(); apply(s); apply(s);

        // IRQ held off three cycles by a jr hazard
        s = quiet(); s.irq = 1; apply(s);
        s.id_jr = 1; s.id_jump = 1; s.id_rs = 5'd7; s.ex_regwr = 1; s.ex_wr_addr = 5'd7;
        repeat (3) apply(s);
        s = quiet(); s.irq = 1; apply(s);
        s.kernel = 1; apply(s); apply(s);
        s = quiet(); apply(s); apply(s);

        // illop in user mode while pending, handler returns, IRQ re-pends
        s = quiet(); s.irq = 1; apply(s);
        s.id_illop = 1; apply(s);
        s = quiet(); s.irq = 1; s.kernel = 1; apply(s); apply(s);
        s = quiet(); s.irq = 1; apply(s); apply(s);
        s = quiet(); s.kernel = 1; apply(s);
        s = quiet(); apply(s);

        // reset in the middle of PEND
        s = quiet(); s.irq = 1; apply(s);
        s = quiet(); s.id_jump = 1; apply(s);
        s = quiet(); s.rst_n = 0; apply(s);
        s = quiet(); apply(s); apply(s);

        // wait counter saturation
        s = quiet(); s.irq = 1; apply(s);
        s = quiet(); s.ex_memrd = 1; s.ex_wr_addr = 5'd9; s.id_rt = 5'd9; s.id_use_rt = 1;
        repeat (300) apply(s);
        s = quiet(); apply(s);
        s.kernel = 1; apply(s);
        s = quiet(); apply(s); apply(s);

        r_kernel = 0;
        repeat (2500) apply(rand_stim());

        repeat (3) @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
